// File: rtl/adc_pkg.sv
// Shared state encoding and channel-search helper for the ADC scan controller.
package adc_pkg;

   localparam int MAX_CH   = 32;
   localparam int MAX_CH_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      START,
      WAIT_EOC,
      SETTLE,
      OUT,
      NEXT
   } state_t;

   typedef struct packed {
      logic                found;
      logic [MAX_CH_W-1:0] idx;
   } ch_pick_t;

   // Lowest set bit strictly above cur, or lowest set bit overall when from_start is set.
   function automatic ch_pick_t next_ch(input logic [MAX_CH-1:0] mask,
                                        input logic [MAX_CH_W-1:0] cur,
                                        input logic from_start);
      ch_pick_t pick;
      pick = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (from_start || (i > int'(cur)))) begin
            pick.found = 1'b1;
            pick.idx   = MAX_CH_W'(i);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by reset_n.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan controller for an external parallel ADC: mux select, start strobe,
// EOC wait with timeout, settle, capture, and {channel, data} hand-off over valid/ready.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter  int DATA_W      = 8,
   parameter  int NUM_CH      = 4,
   parameter  int START_CYC   = 4,
   parameter  int SETTLE_CYC  = 25,
   parameter  int TIMEOUT_CYC = 1023,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              stop,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              adc_eoc,
   input  logic [DATA_W-1:0] adc_data,
   output logic              adc_start_n,
   output logic [CH_W-1:0]   adc_ch_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              busy,
   output logic              scan_done,
   output logic              timeout_err
);

   localparam int CNT_MAX_A = (START_CYC > SETTLE_CYC) ? START_CYC : SETTLE_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic                cont_q, cont_d;
   logic                stop_pend_q, stop_pend_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [CH_W-1:0]     out_ch_q, out_ch_d;
   logic                timeout_q, timeout_d;
   logic                start_n_q;
   logic                eoc_s, eoc_prev_q, eoc_rise;
   logic                scan_done_c;
   ch_pick_t            pick_first, pick_wrap, pick_up;
   logic                unused_pick;

   sync_2ff u_eoc_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (adc_eoc),
      .q       (eoc_s)
   );

   assign eoc_rise = eoc_s & ~eoc_prev_q;

   assign pick_first = next_ch(MAX_CH'(ch_mask), '0, 1'b1);
   assign pick_wrap  = next_ch(MAX_CH'(mask_q), '0, 1'b1);
   assign pick_up    = next_ch(MAX_CH'(mask_q), MAX_CH_W'(ch_q), 1'b0);
   assign unused_pick = ^{pick_first, pick_wrap, pick_up};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ch_q        <= '0;
         mask_q      <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         timeout_q   <= 1'b0;
         start_n_q   <= 1'b1;
         eoc_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         mask_q      <= mask_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         timeout_q   <= timeout_d;
         start_n_q   <= (state_d != START);
         eoc_prev_q  <= eoc_s;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      mask_d      = mask_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q | ((state_q != IDLE) & stop);
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      timeout_d   = timeout_q;
      scan_done_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && pick_first.found) begin
               mask_d      = ch_mask;
               cont_d      = continuous;
               stop_pend_d = stop;
               timeout_d   = 1'b0;
               ch_d        = CH_W'(pick_first.idx);
               state_d     = SEL;
            end
         end
         SEL: begin
            cnt_d   = '0;
            state_d = START;
         end
         START: begin
            if (cnt_q == CNT_W'(START_CYC - 1)) begin
               cnt_d   = '0;
               state_d = WAIT_EOC;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_EOC: begin
            if (eoc_rise) begin
               cnt_d   = '0;
               state_d = SETTLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               // The conversion is abandoned; the channel produces no sample this pass.
               timeout_d = 1'b1;
               state_d   = NEXT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC)) begin
               out_data_d  = adc_data;
               out_ch_d    = ch_q;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = NEXT;
            end
         end
         NEXT: begin
            if (pick_up.found) begin
               ch_d    = CH_W'(pick_up.idx);
               state_d = SEL;
            end else begin
               scan_done_c = 1'b1;
               if (cont_q && !(stop_pend_q || stop) && pick_wrap.found) begin
                  ch_d    = CH_W'(pick_wrap.idx);
                  state_d = SEL;
               end else begin
                  stop_pend_d = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign adc_start_n = start_n_q;
   assign adc_ch_sel  = ch_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_ch      = out_ch_q;
   assign busy        = (state_q != IDLE);
   assign scan_done   = scan_done_c;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: behavioural ADC, sample monitor and scan-order reference model.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

   typedef struct packed {
      logic       dead;
      logic [1:0] ch;
      logic [7:0] data;
   } conv_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] ch_mask = 4'h0;
   logic       adc_eoc = 1'b0;
   logic [7:0] adc_data = 8'h00;
   logic       out_ready = 1'b1;
   logic       adc_start_n, out_valid, busy, scan_done, timeout_err;
   logic [1:0] adc_ch_sel, out_ch;
   logic [7:0] out_data;

   int tests_run = 0;
   int fails = 0;

   // ADC model knobs and logs
   logic [3:0]  dead_mask = 4'h0;
   int          eoc_delay = 10;
   int          eoc_cnt = 0;
   logic        sn_prev = 1'b1;
   logic [7:0]  next_data = 8'h5a;
   conv_t       conv_q[$];
   logic [9:0]  got_q[$];
   int          done_cnt = 0;
   int          low_run = 0;
   int          w_min = 1000;
   int          w_max = 0;

   adc_scan_ctrl #(
      .DATA_W(8), .NUM_CH(4), .START_CYC(4), .SETTLE_CYC(25), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .stop(stop),
      .ch_mask(ch_mask), .adc_eoc(adc_eoc), .adc_data(adc_data), .adc_start_n(adc_start_n),
      .adc_ch_sel(adc_ch_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Behavioural ADC: a falling start strobe begins a conversion on the selected channel.
   always @(negedge clk) begin
      sn_prev <= adc_start_n;
      if (sn_prev && !adc_start_n) begin
         adc_eoc   <= 1'b0;
         adc_data  <= next_data;
         conv_q.push_back({dead_mask[adc_ch_sel], adc_ch_sel, next_data});
         next_data <= 8'($urandom);
         eoc_cnt   <= dead_mask[adc_ch_sel] ? 0 : eoc_delay;
      end else if (eoc_cnt != 0) begin
         eoc_cnt <= eoc_cnt - 1;
         if (eoc_cnt == 1) adc_eoc <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) got_q.push_back({out_ch, out_data});
      if (reset_n && scan_done) done_cnt <= done_cnt + 1;
      if (!reset_n) low_run <= 0;
      else if (!adc_start_n) low_run <= low_run + 1;
      else if (low_run != 0) begin
         if (low_run < w_min) w_min <= low_run;
         if (low_run > w_max) w_max <= low_run;
         low_run <= 0;
      end
   end

   function automatic int popc(logic [3:0] m);
      int n = 0;
      for (int c = 0; c < 4; c++) n += int'(m[c]);
      return n;
   endfunction

   // k-th channel converted when scanning mask m repeatedly in ascending order
   function automatic int exp_ch_at(logic [3:0] m, int k);
      int lst[4];
      int n = 0;
      for (int c = 0; c < 4; c++) if (m[c]) begin lst[n] = c; n++; end
      if (n == 0) return -1;
      return lst[k % n];
   endfunction

   // j-th delivered sample expected from conversions logged since index cb
   function automatic logic [9:0] exp_sample(int cb, int j);
      int seen = 0;
      for (int i = cb; i < conv_q.size(); i++) begin
         if (!conv_q[i].dead) begin
            if (seen == j) return {conv_q[i].ch, conv_q[i].data};
            seen++;
         end
      end
      return 'x;
   endfunction

   task automatic do_start(input logic [3:0] m, input logic cont, input logic stp);
      @(posedge clk); #1;
      ch_mask = m; continuous = cont; stop = stp; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic wait_start_n(input logic lvl, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (adc_start_n === lvl) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk); #1;
      tests_run++;
      if ({adc_start_n, out_valid, busy, scan_done, timeout_err} !== 5'b10000) begin
         fails++; $display("FAIL reset_ctrl: got %b want 10000", {adc_start_n, out_valid, busy, scan_done, timeout_err});
      end
      tests_run++;
      if ({adc_ch_sel, out_ch, out_data} !== 12'h000) begin
         fails++; $display("FAIL reset_data: got %h want 000", {adc_ch_sel, out_ch, out_data});
      end
      reset_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_single_scan();
      int cb, gb, db; logic ok;
      cb = conv_q.size(); gb = got_q.size(); db = done_cnt;
      dead_mask = 4'h0; eoc_delay = 10; out_ready = 1'b1;
      do_start(4'b0101, 1'b0, 1'b0);
      wait_idle(3000, ok);
      tests_run++;
      if (ok !== 1'b1) begin fails++; $display("FAIL t1_idle: busy stuck, got %b want 1", ok); end
      tests_run++;
      if (done_cnt - db !== 1) begin fails++; $display("FAIL t1_done: got %0d want 1", done_cnt - db); end
      tests_run++;
      if (conv_q.size() - cb !== 2) begin fails++; $display("FAIL t1_convs: got %0d want 2", conv_q.size() - cb); end
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if (int'(conv_q[cb+k].ch) !== exp_ch_at(4'b0101, k)) begin
            fails++; $display("FAIL t1_order[%0d]: got %0d want %0d", k, conv_q[cb+k].ch, exp_ch_at(4'b0101, k));
         end
      end
      tests_run++;
      if (got_q.size() - gb !== 2) begin fails++; $display("FAIL t1_nsamp: got %0d want 2", got_q.size() - gb); end
      for (int j = 0; j < 2; j++) begin
         tests_run++;
         if (got_q[gb+j] !== exp_sample(cb, j)) begin
            fails++; $display("FAIL t1_sample[%0d]: got %h want %h", j, got_q[gb+j], exp_sample(cb, j));
         end
      end
   endtask

   task automatic test_backpressure();
      int cb, gb, nconv; logic ok, unstable; logic [9:0] snap;
      cb = conv_q.size(); gb = got_q.size();
      eoc_delay = $urandom_range(6, 12); out_ready = 1'b0;
      do_start(4'b0010, 1'b0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
      end
      tests_run++;
      if (ok !== 1'b1) begin fails++; $display("FAIL t2_valid: got %b want 1", ok); end
      snap = {out_ch, out_data}; nconv = conv_q.size(); unstable = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (!out_valid || ({out_ch, out_data} !== snap)) unstable = 1'b1;
      end
      tests_run++;
      if (unstable !== 1'b0) begin fails++; $display("FAIL t2_stable: got %b want 0", unstable); end
      tests_run++;
      if (conv_q.size() !== nconv) begin fails++; $display("FAIL t2_nostart: got %0d want %0d", conv_q.size(), nconv); end
      tests_run++;
      if (snap !== exp_sample(cb, 0)) begin fails++; $display("FAIL t2_held: got %h want %h", snap, exp_sample(cb, 0)); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_idle(500, ok);
      tests_run++;
      if ((got_q.size() - gb !== 1) || (got_q[gb] !== exp_sample(cb, 0))) begin
         fails++; $display("FAIL t2_xfer: got n=%0d %h want n=1 %h", got_q.size() - gb, got_q[gb], exp_sample(cb, 0));
      end
   endtask

   task automatic test_timeout();
      int cb, gb, n; logic ok, ok2;
      cb = conv_q.size(); gb = got_q.size();
      dead_mask = 4'b0001; eoc_delay = $urandom_range(6, 12); out_ready = 1'b1;
      do_start(4'b0011, 1'b0, 1'b0);
      wait_start_n(1'b0, 100, ok);
      wait_start_n(1'b1, 100, ok2);
      n = 0;
      while (!timeout_err && n < 200) begin n++; @(negedge clk); end
      tests_run++;
      if (n !== 16 || !ok || !ok2) begin fails++; $display("FAIL t3_tmo_cycles: got %0d want 16", n); end
      wait_idle(3000, ok);
      tests_run++;
      if ({ok, timeout_err} !== 2'b11) begin fails++; $display("FAIL t3_sticky: got %b want 11", {ok, timeout_err}); end
      tests_run++;
      if ((conv_q.size() - cb !== 2) || (conv_q[cb].ch !== 2'd0) || (conv_q[cb+1].ch !== 2'd1)) begin
         fails++; $display("FAIL t3_order: got n=%0d want ch0,ch1", conv_q.size() - cb);
      end
      tests_run++;
      if ((got_q.size() - gb !== 1) || (got_q[gb] !== exp_sample(cb, 0)) || (got_q[gb][9:8] !== 2'd1)) begin
         fails++; $display("FAIL t3_ch1only: got n=%0d %h want n=1 %h", got_q.size() - gb, got_q[gb], exp_sample(cb, 0));
      end
      dead_mask = 4'h0;
   endtask

   task automatic test_continuous_stop();
      int cb, gb, db; logic ok;
      cb = conv_q.size(); gb = got_q.size(); db = done_cnt;
      eoc_delay = $urandom_range(6, 12); out_ready = 1'b1;
      do_start(4'b1000, 1'b1, 1'b0);
      tests_run++;
      if (timeout_err !== 1'b0) begin fails++; $display("FAIL t4_err_clr: got %b want 0", timeout_err); end
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (conv_q.size() - cb >= 3) begin ok = 1'b1; break; end
      end
      repeat (3) @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      wait_idle(3000, ok);
      tests_run++;
      if (ok !== 1'b1) begin fails++; $display("FAIL t4_idle: got %b want 1", ok); end
      tests_run++;
      if (done_cnt - db !== 3) begin fails++; $display("FAIL t4_done: got %0d want 3", done_cnt - db); end
      tests_run++;
      if (got_q.size() - gb !== 3) begin fails++; $display("FAIL t4_nsamp: got %0d want 3", got_q.size() - gb); end
      for (int j = 0; j < 3; j++) begin
         tests_run++;
         if ((got_q[gb+j] !== exp_sample(cb, j)) || (got_q[gb+j][9:8] !== 2'd3)) begin
            fails++; $display("FAIL t4_sample[%0d]: got %h want %h", j, got_q[gb+j], exp_sample(cb, j));
         end
      end
   endtask

   task automatic test_random();
      int cb, gb, db; logic ok; logic [3:0] m;
      for (int it = 0; it < 5; it++) begin
         cb = conv_q.size(); gb = got_q.size(); db = done_cnt;
         m = 4'($urandom_range(1, 15));
         dead_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         eoc_delay = $urandom_range(6, 12);
         do_start(m, 1'b0, 1'b0);
         ok = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (!busy) begin ok = 1'b1; break; end
         end
         out_ready = 1'b1;
         repeat (2) @(negedge clk); #1;
         tests_run++;
         if ({ok, timeout_err} !== {1'b1, |(m & dead_mask)}) begin
            fails++; $display("FAIL rnd_err[%0d]: got %b want %b", it, {ok, timeout_err}, {1'b1, |(m & dead_mask)});
         end
         tests_run++;
         if ((conv_q.size() - cb !== popc(m)) || (done_cnt - db !== 1)) begin
            fails++; $display("FAIL rnd_convs[%0d]: got %0d/%0d want %0d/1", it, conv_q.size() - cb, done_cnt - db, popc(m));
         end
         for (int k = 0; k < popc(m); k++) begin
            tests_run++;
            if (int'(conv_q[cb+k].ch) !== exp_ch_at(m, k)) begin
               fails++; $display("FAIL rnd_order[%0d.%0d]: got %0d want %0d", it, k, conv_q[cb+k].ch, exp_ch_at(m, k));
            end
         end
         tests_run++;
         if (got_q.size() - gb !== popc(m & ~dead_mask)) begin
            fails++; $display("FAIL rnd_nsamp[%0d]: got %0d want %0d", it, got_q.size() - gb, popc(m & ~dead_mask));
         end
         for (int j = 0; j < popc(m & ~dead_mask); j++) begin
            tests_run++;
            if (got_q[gb+j] !== exp_sample(cb, j)) begin
               fails++; $display("FAIL rnd_sample[%0d.%0d]: got %h want %h", it, j, got_q[gb+j], exp_sample(cb, j));
            end
         end
      end
      dead_mask = 4'h0;
   endtask

   task automatic test_reset_mid();
      int cb, gb, db; logic ok, ok2;
      eoc_delay = 10;
      do_start(4'b0100, 1'b0, 1'b0);
      wait_start_n(1'b0, 100, ok);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({ok, adc_start_n, busy} !== 3'b110) begin fails++; $display("FAIL t5_start_rel: got %b want 110", {ok, adc_start_n, busy}); end
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      do_start(4'b0100, 1'b0, 1'b0);
      wait_start_n(1'b0, 100, ok);
      wait_start_n(1'b1, 100, ok2);
      repeat (3) @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({ok, ok2, adc_start_n, out_valid, busy, scan_done, adc_ch_sel} !== 8'b11100000) begin
         fails++; $display("FAIL t5_wait_eoc: got %b want 11100000", {ok, ok2, adc_start_n, out_valid, busy, scan_done, adc_ch_sel});
      end
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      cb = conv_q.size(); gb = got_q.size(); db = done_cnt;
      do_start(4'b0010, 1'b0, 1'b0);
      wait_idle(3000, ok);
      tests_run++;
      if ({ok, done_cnt - db, got_q.size() - gb} !== {1'b1, 32'd1, 32'd1}) begin
         fails++; $display("FAIL t5_after: got ok=%b done=%0d n=%0d want 1 1 1", ok, done_cnt - db, got_q.size() - gb);
      end
      tests_run++;
      if (got_q[gb] !== exp_sample(cb, 0)) begin fails++; $display("FAIL t5_sample: got %h want %h", got_q[gb], exp_sample(cb, 0)); end
   endtask

   task automatic test_edge_cases();
      int cb, gb, db; logic ok, busy_seen;
      cb = conv_q.size();
      do_start(4'b0000, 1'b1, 1'b0);
      busy_seen = 1'b0;
      repeat (20) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
      tests_run++;
      if ({busy_seen, conv_q.size() - cb} !== {1'b0, 32'd0}) begin
         fails++; $display("FAIL t6_mask0: got busy=%b convs=%0d want 0 0", busy_seen, conv_q.size() - cb);
      end
      cb = conv_q.size(); gb = got_q.size(); db = done_cnt;
      do_start(4'b0001, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      do_start(4'b1111, 1'b1, 1'b0);
      wait_idle(3000, ok);
      tests_run++;
      if ({ok, done_cnt - db, conv_q.size() - cb, got_q.size() - gb} !== {1'b1, 32'd1, 32'd1, 32'd1}) begin
         fails++; $display("FAIL t6_busy_start: got done=%0d convs=%0d n=%0d want 1 1 1", done_cnt - db, conv_q.size() - cb, got_q.size() - gb);
      end
      tests_run++;
      if (got_q[gb] !== exp_sample(cb, 0)) begin fails++; $display("FAIL t6_busy_sample: got %h want %h", got_q[gb], exp_sample(cb, 0)); end
      cb = conv_q.size(); gb = got_q.size(); db = done_cnt;
      do_start(4'b0110, 1'b1, 1'b1);
      wait_idle(3000, ok);
      tests_run++;
      if ({ok, done_cnt - db, got_q.size() - gb} !== {1'b1, 32'd1, 32'd2}) begin
         fails++; $display("FAIL t6_start_stop: got done=%0d n=%0d want 1 2", done_cnt - db, got_q.size() - gb);
      end
      for (int j = 0; j < 2; j++) begin
         tests_run++;
         if ((got_q[gb+j] !== exp_sample(cb, j)) || (int'(got_q[gb+j][9:8]) !== exp_ch_at(4'b0110, j))) begin
            fails++; $display("FAIL t6_ss_sample[%0d]: got %h want %h", j, got_q[gb+j], exp_sample(cb, j));
         end
      end
      tests_run++;
      if ({w_min, w_max} !== {32'd4, 32'd4}) begin
         fails++; $display("FAIL t6_start_width: got min=%0d max=%0d want 4 4", w_min, w_max);
      end
   endtask

   initial begin
      test_reset();
      test_single_scan();
      test_backpressure();
      test_timeout();
      test_continuous_stop();
      test_random();
      test_reset_mid();
      test_edge_cases();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
